tank_spawn_sched: RTL and testbench
===================================

Name: tank_spawn_sched

Overview:
- Parametrised enemy-tank spawn scheduler, successor to the fixed four-tank generator; drives per-tank enable pulses into the enemy tank instances.
- Runs a staggered intro wave, then respawns each dead tank after a programmable delay.
- Adds round-robin arbitration so at most one tank spawns at a time, a total-spawn budget, and a restart input.

Parameters:
- N_TANKS, 4, number of enemy tank slots (2..8).
- INTRO_DELAY, 4, ticks after intro start before slot 0 is enabled.
- INTRO_GAP, 12, ticks each intro slot's enable is held before the next slot starts.
- RESPAWN_DELAY, 12, ticks a slot must be dead before it requests a respawn (1..255).
- EN_PULSE, 4, ticks tank_en is held high for a respawn (1..255).
- SPAWN_LIMIT, 0, total spawns per wave including intro; 0 means unlimited.

Ports:
- clk_4Hz  in  1  game tick clock.
- rst  in  1  asynchronous active-high reset.
- restart  in  1  synchronous; restarts the intro wave.
- tank_state  in  N_TANKS  1 = tank alive, 0 = dead.
- tank_en  out  N_TANKS  spawn enable, one-hot or zero.
- spawn_cnt  out  8  spawns issued this wave, saturating at 255.
- phase  out  2  0 = INTRO, 1 = RUN, 2 = DONE.
- wave_done  out  1  high in DONE.

Behaviour:
- Reset values: tank_en=0, spawn_cnt=0, phase=INTRO, wave_done=0. All counters clear and the round-robin pointer resets to slot 0.
- INTRO: tick counter t starts at 0 and increments every clk_4Hz.
  - Slot k's tank_en is high for t in [INTRO_DELAY+k*INTRO_GAP, INTRO_DELAY+(k+1)*INTRO_GAP-1].
  - spawn_cnt increments on the cycle each slot's enable rises.
  - At t = INTRO_DELAY + N_TANKS*INTRO_GAP, all enables are low and phase goes to RUN.
  - If the budget is exhausted mid-intro, the remaining slots are skipped and phase goes to RUN.
  - tank_state is ignored during INTRO.
- RUN, per slot:
  - Dead counter d[k] holds 0 while tank_state[k]=1 or the slot is enabled.
  - Otherwise d[k] increments, saturating at RESPAWN_DELAY.
  - req[k] = (d[k]==RESPAWN_DELAY) and the budget is not exhausted.
- Arbiter:
  - When no slot is enabled and any req is set, grant the first requesting slot at or after the pointer, wrapping.
  - Registered: tank_en[g] rises the cycle after req is seen.
  - Hold tank_en[g] for exactly EN_PULSE cycles, then drop it.
  - On the drop cycle, clear d[g] and set the pointer to g+1 mod N_TANKS.
  - spawn_cnt increments on the grant cycle.
  - Requests arriving during a pulse wait; they are never lost.
- Budget exhausted: SPAWN_LIMIT!=0 and spawn_cnt==SPAWN_LIMIT.
- DONE is entered from RUN when the budget is exhausted, no enable is active, and tank_state is all zero. DONE holds all enables at 0 until restart or rst.
- restart (any phase, including mid-pulse):
  - Next cycle: tank_en=0, all d cleared, spawn_cnt=0, pointer=0, t=0, phase=INTRO.
  - restart has priority over all other events in the same cycle.
- tank_state rising during the enable pulse has no effect on pulse length.

Optional Feature:
- Macro TANK_SPAWN_PAUSE_EN.
- Defined: adds input port pause (1 bit). While pause=1:
  - t, all d[k], and the pulse counter freeze; tank_en holds its value.
  - No new grant is issued.
  - restart still takes effect.
- Undefined: no pause port; behaviour as above.

Decomposition:
- Package tank_game_pkg holds:
  - phase encodings PH_INTRO/PH_RUN/PH_DONE;
  - MAX_TANKS=8;
  - the counter width constant (8 bits) for the delay counters.
- One sub-module, tank_rr_arb: N-way round-robin arbiter with pointer and grant outputs, instantiated once.

Test Plan:
- Defaults, rst released: tank_en = 0001 during t=4..15, 0010 during t=16..27, 0100 during t=28..39, 1000 during t=40..51; phase=RUN at t=52; spawn_cnt=4.
- RUN with slot 2 dying (tank_state=1011): tank_en[2] rises 13 cycles after the death and stays high 4 cycles; d[2] clears after the pulse.
- Slots 0 and 3 die in the same cycle with pointer=1: slot 3 is granted first (4 cycles), then slot 0 one cycle after slot 3's enable drops.
- SPAWN_LIMIT=6, all tanks repeatedly dying: exactly 2 respawns after the intro; spawn_cnt=6; wave_done=1 once tank_state=0000.
- restart asserted during a RUN pulse on slot 1: tank_en=0000 next cycle, spawn_cnt=0, phase=INTRO, and the intro repeats with the first test's timing.
- TANK_SPAWN_PAUSE_EN, pause=1 for 10 cycles mid-pulse: tank_en holds high, and the pulse ends 10 cycles later than in the unpaused case.

Source files
------------

// File: rtl/tank_game_pkg.sv
// Shared types and constants for the enemy-tank spawn scheduler.
// Optional pause input is enabled by defining TANK_SPAWN_PAUSE_EN.
package tank_game_pkg;

  typedef enum logic [1:0] {
    PH_INTRO = 2'd0,
    PH_RUN   = 2'd1,
    PH_DONE  = 2'd2
  } phase_e;

  localparam int MAX_TANKS = 8;
  localparam int CNT_W     = 8;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/tank_rr_arb.sv
// N-way round-robin arbiter: combinational grant starting at the pointer,
// pointer moves past the slot whose service has just finished.
module tank_rr_arb #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [N-1:0]  req,
  input  logic          advance,
  input  logic [IW-1:0] adv_idx,
  output logic [IW-1:0] ptr_o,
  output logic [N-1:0]  gnt_o,
  output logic          gnt_vld_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] slot;
  logic          found;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (advance) begin
      ptr_d = (adv_idx == IW'(N - 1)) ? '0 : adv_idx + IW'(1);
    end
  end

  // Scan from the pointer upward, wrapping, and keep the first requester.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    slot  = '0;
    for (int i = 0; i < N; i++) begin
      slot = (int'(ptr_q) + i >= N) ? IW'(int'(ptr_q) + i - N) : IW'(int'(ptr_q) + i);
      if (!found && req[slot]) begin
        gnt_o[slot] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign gnt_vld_o = |req;
  assign ptr_o     = ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/tank_spawn_sched.sv
// Enemy-tank spawn scheduler: staggered intro wave, then arbitrated respawns
// under an optional spawn budget. Define TANK_SPAWN_PAUSE_EN to add a pause input.
module tank_spawn_sched
  import tank_game_pkg::*;
#(
  parameter int N_TANKS       = 4,
  parameter int INTRO_DELAY   = 4,
  parameter int INTRO_GAP     = 12,
  parameter int RESPAWN_DELAY = 12,
  parameter int EN_PULSE      = 4,
  parameter int SPAWN_LIMIT   = 0
) (
  input  logic               clk_4Hz,
  input  logic               rst,
  input  logic               restart,
`ifdef TANK_SPAWN_PAUSE_EN
  input  logic               pause,
`endif
  input  logic [N_TANKS-1:0] tank_state,
  output logic [N_TANKS-1:0] tank_en,
  output logic [7:0]         spawn_cnt,
  output logic [1:0]         phase,
  output logic               wave_done
);

  localparam int              IW        = $clog2(N_TANKS);
  localparam logic [15:0]     INTRO_END = 16'(INTRO_DELAY + N_TANKS * INTRO_GAP);
  localparam logic [CNT_W-1:0] RESP_D   = CNT_W'(RESPAWN_DELAY);
  localparam logic [7:0]      PULSE_LEN = 8'(EN_PULSE);

  phase_e                         phase_q, phase_d;
  logic [15:0]                    t_q, t_d, t_next;
  logic [N_TANKS-1:0][CNT_W-1:0]  d_q, d_d, d_inc;
  logic [N_TANKS-1:0]             en_q, en_d;
  logic [N_TANKS-1:0]             intro_en, intro_start, req, gnt;
  logic [7:0]                     cnt_q, cnt_d, pulse_q, pulse_d;
  logic                           done_q, done_d;
  logic                           hold, exhausted, drop, gnt_vld;
  logic [IW-1:0]                  cur_idx, arb_ptr_unused;

`ifdef TANK_SPAWN_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  assign t_next    = t_q + 16'd1;
  assign exhausted = (SPAWN_LIMIT != 0) && (int'(cnt_q) == SPAWN_LIMIT);

  genvar gi;
  generate
    for (gi = 0; gi < N_TANKS; gi++) begin : g_slot
      localparam logic [15:0] ON_T  = 16'(INTRO_DELAY + gi * INTRO_GAP);
      localparam logic [15:0] OFF_T = 16'(INTRO_DELAY + (gi + 1) * INTRO_GAP);

      assign intro_start[gi] = (t_next == ON_T);
      assign intro_en[gi]    = (t_next >= ON_T) && (t_next < OFF_T);
      assign req[gi]         = (d_q[gi] == RESP_D) && !exhausted;
      // Dead time only accumulates while the slot is dead and not being spawned.
      assign d_inc[gi] = (tank_state[gi] || en_q[gi]) ? '0 :
                         (d_q[gi] == RESP_D)          ? d_q[gi] :
                                                        d_q[gi] + CNT_W'(1);
    end
  endgenerate

  always_comb begin
    cur_idx = '0;
    for (int k = 0; k < N_TANKS; k++) begin
      if (en_q[k]) cur_idx = IW'(k);
    end
  end

  tank_rr_arb #(
    .N (N_TANKS)
  ) u_arb (
    .clk       (clk_4Hz),
    .rst       (rst),
    .clr       (restart),
    .req       (req),
    .advance   (drop),
    .adv_idx   (cur_idx),
    .ptr_o     (arb_ptr_unused),
    .gnt_o     (gnt),
    .gnt_vld_o (gnt_vld)
  );

  always_comb begin
    phase_d = phase_q;
    t_d     = t_q;
    d_d     = d_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    pulse_d = pulse_q;
    drop    = 1'b0;
    if (restart) begin
      phase_d = PH_INTRO;
      t_d     = '0;
      d_d     = '0;
      en_d    = '0;
      cnt_d   = '0;
      pulse_d = '0;
    end else if (!hold) begin
      unique case (phase_q)
        PH_INTRO: begin
          t_d = t_next;
          if (t_next == INTRO_END || ((|intro_start) && exhausted)) begin
            phase_d = PH_RUN;
            en_d    = '0;
          end else begin
            en_d = intro_en;
            if (|intro_start) cnt_d = sat_inc8(cnt_q);
          end
        end
        PH_RUN: begin
          d_d = d_inc;
          if (|en_q) begin
            if (pulse_q == PULSE_LEN) begin
              en_d         = '0;
              drop         = 1'b1;
              d_d[cur_idx] = '0;
            end else begin
              pulse_d = pulse_q + 8'd1;
            end
          end else if (gnt_vld) begin
            en_d    = gnt;
            pulse_d = 8'd1;
            cnt_d   = sat_inc8(cnt_q);
          end else if (exhausted && tank_state == '0) begin
            phase_d = PH_DONE;
          end
        end
        default: en_d = '0;
      endcase
    end
    done_d = (phase_d == PH_DONE);
  end

  always_ff @(posedge clk_4Hz or posedge rst) begin
    if (rst) begin
      phase_q <= PH_INTRO;
      t_q     <= '0;
      d_q     <= '0;
      en_q    <= '0;
      cnt_q   <= '0;
      pulse_q <= '0;
      done_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      t_q     <= t_d;
      d_q     <= d_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
    end
  end

  assign tank_en   = en_q;
  assign spawn_cnt = cnt_q;
  assign phase     = phase_q;
  assign wave_done = done_q;

endmodule

// File: tb/tb_tank_spawn_sched.sv
// Bench for tank_spawn_sched: two instances (unlimited and budget of 6) run in
// lockstep against a slot-level reference model; TANK_SPAWN_PAUSE_EN adds pause tests.
module tb_tank_spawn_sched;

  localparam int N  = 4;
  localparam int ID = 4;
  localparam int IG = 12;
  localparam int RD = 12;
  localparam int EP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       restart = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] tank_state = 4'hF;

  logic [3:0] en_a, en_b;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] ph_a, ph_b;
  logic       wd_a, wd_b;

  always #5 clk = ~clk;

  tank_spawn_sched #(
    .N_TANKS(N), .INTRO_DELAY(ID), .INTRO_GAP(IG),
    .RESPAWN_DELAY(RD), .EN_PULSE(EP), .SPAWN_LIMIT(0)
  ) dut_a (
    .clk_4Hz   (clk),
    .rst       (rst),
    .restart   (restart),
`ifdef TANK_SPAWN_PAUSE_EN
    .pause     (pause),
`endif
    .tank_state(tank_state),
    .tank_en   (en_a),
    .spawn_cnt (cnt_a),
    .phase     (ph_a),
    .wave_done (wd_a)
  );

  tank_spawn_sched #(
    .N_TANKS(N), .INTRO_DELAY(ID), .INTRO_GAP(IG),
    .RESPAWN_DELAY(RD), .EN_PULSE(EP), .SPAWN_LIMIT(6)
  ) dut_b (
    .clk_4Hz   (clk),
    .rst       (rst),
    .restart   (restart),
`ifdef TANK_SPAWN_PAUSE_EN
    .pause     (pause),
`endif
    .tank_state(tank_state),
    .tank_en   (en_b),
    .spawn_cnt (cnt_b),
    .phase     (ph_b),
    .wave_done (wd_b)
  );

  // Reference model: slot currently spawning (-1 none), countdown of its pulse.
  int m_phase[2];
  int m_t[2];
  int m_en[2];
  int m_left[2];
  int m_ptr[2];
  int m_cnt[2];
  int m_d[2][N];

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int limit_of(int m);
    return (m == 0) ? 0 : 6;
  endfunction

  function automatic int exp_en(int m);
    return (m_en[m] < 0) ? 0 : (1 << m_en[m]);
  endfunction

  task automatic model_reset(int m);
    m_phase[m] = 0;
    m_t[m]     = 0;
    m_en[m]    = -1;
    m_left[m]  = 0;
    m_ptr[m]   = 0;
    m_cnt[m]   = 0;
    for (int k = 0; k < N; k++) m_d[m][k] = 0;
  endtask

  task automatic model_step(int m);
    int  nd[N];
    int  g;
    int  s;
    bit  exh;
    exh = (limit_of(m) != 0) && (m_cnt[m] == limit_of(m));
    if (restart) begin
      model_reset(m);
      return;
    end
    if (pause) return;
    case (m_phase[m])
      0: begin
        m_t[m]++;
        if (m_t[m] == ID + N * IG) begin
          m_phase[m] = 1;
          m_en[m]    = -1;
        end else if (m_t[m] >= ID && (m_t[m] - ID) % IG == 0) begin
          if (exh) begin
            m_phase[m] = 1;
            m_en[m]    = -1;
          end else begin
            m_en[m]  = (m_t[m] - ID) / IG;
            m_cnt[m] = (m_cnt[m] < 255) ? m_cnt[m] + 1 : 255;
          end
        end
      end
      1: begin
        for (int k = 0; k < N; k++) begin
          if (tank_state[k] || m_en[m] == k) nd[k] = 0;
          else nd[k] = (m_d[m][k] < RD) ? m_d[m][k] + 1 : RD;
        end
        if (m_en[m] >= 0) begin
          m_left[m]--;
          if (m_left[m] == 0) begin
            nd[m_en[m]] = 0;
            m_ptr[m]    = (m_en[m] + 1) % N;
            m_en[m]     = -1;
          end
        end else begin
          g = -1;
          if (!exh) begin
            for (int j = 0; j < N; j++) begin
              s = (m_ptr[m] + j) % N;
              if (g < 0 && m_d[m][s] == RD) g = s;
            end
          end
          if (g >= 0) begin
            m_en[m]   = g;
            m_left[m] = EP;
            m_cnt[m]  = (m_cnt[m] < 255) ? m_cnt[m] + 1 : 255;
          end else if (exh && tank_state == 4'b0000) begin
            m_phase[m] = 2;
          end
        end
        for (int k = 0; k < N; k++) m_d[m][k] = nd[k];
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    check_val("en_a", en_a, exp_en(0));
    check_val("cnt_a", cnt_a, m_cnt[0]);
    check_val("phase_a", ph_a, m_phase[0]);
    check_val("done_a", wd_a, m_phase[0] == 2);
    check_val("en_b", en_b, exp_en(1));
    check_val("cnt_b", cnt_b, m_cnt[1]);
    check_val("phase_b", ph_b, m_phase[1]);
    check_val("done_b", wd_b, m_phase[1] == 2);
  endtask

  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Intro timing with default parameters, checked against fixed windows.
  task automatic run_intro(input string name);
    for (int i = 1; i <= 56; i++) begin
      tick();
      check_val({name, "_en"}, en_a, (i >= 4 && i < 52) ? (1 << ((i - 4) / 12)) : 0);
      if (i == 52) begin
        check_val({name, "_run"}, ph_a, 1);
        check_val({name, "_cnt"}, cnt_a, 4);
      end
    end
    $display("[TB] txn %s complete, failures so far %0d", name, tests_failed);
  endtask

  task automatic run_pulse(input int maxc, output logic [3:0] first_grant,
                           output int rise, output int fall);
    first_grant = '0;
    rise = -1;
    fall = -1;
    for (int i = 1; i <= maxc; i++) begin
      tick();
      if (rise < 0 && en_a != 4'b0000) begin
        rise = i;
        first_grant = en_a;
      end else if (rise >= 0 && en_a == 4'b0000) begin
        fall = i;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] fg;
    int rise, fall, found, hi;

    model_reset(0);
    model_reset(1);
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    $display("[TB] txn reset checked");
    rst = 1'b0;

    run_intro("intro1");

    // Slot 2 dies: respawn 13 cycles later for 4 cycles.
    tank_state = 4'b1011;
    run_pulse(40, fg, rise, fall);
    check_val("slot2_grant", fg, 4'b0100);
    check_val("slot2_rise", rise, 13);
    check_val("slot2_width", fall - rise, EP);
    tank_state = 4'hF;
    tick();
    tick();
    $display("[TB] txn slot2 respawn rise=%0d fall=%0d", rise, fall);

    // Slot 0 respawn moves the pointer to 1.
    tank_state = 4'b1110;
    run_pulse(40, fg, rise, fall);
    check_val("slot0_grant", fg, 4'b0001);
    tank_state = 4'hF;
    tick();
    tick();
    $display("[TB] txn slot0 respawn rise=%0d", rise);

    // Slots 0 and 3 die together with pointer at 1.
    tank_state = 4'b0110;
    run_pulse(40, fg, rise, fall);
    check_val("rr_first", fg, 4'b1000);
    check_val("rr_first_width", fall - rise, EP);
    run_pulse(40, fg, rise, fall);
    check_val("rr_second", fg, 4'b0001);
    check_val("rr_second_rise", rise, 1);
    check_val("budget_cnt", cnt_b, 6);
    $display("[TB] txn round-robin pair checked");

    tank_state = 4'b0000;
    repeat (3) tick();
    check_val("budget_done", wd_b, 1);
    check_val("budget_phase", ph_b, 2);
    $display("[TB] txn budget done checked");

    // Restart during a pulse on slot 1.
    tank_state = 4'b1101;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (en_a == 4'b0010) begin
        found = 1;
        break;
      end
    end
    check_val("restart_pulse_found", found, 1);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check_val("restart_en", en_a, 0);
    check_val("restart_cnt", cnt_a, 0);
    check_val("restart_phase", ph_a, 0);
    tank_state = 4'hF;
    run_intro("intro2");

`ifdef TANK_SPAWN_PAUSE_EN
    tank_state = 4'b1011;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (en_a[2]) begin
        found = 1;
        break;
      end
    end
    check_val("pause_rise_found", found, 1);
    hi = 1;
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("pause_hold", en_a[2], 1);
      if (en_a[2]) hi++;
    end
    pause = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!en_a[2]) break;
      hi++;
    end
    check_val("pause_width", hi, EP + 10);
    tank_state = 4'hF;
    $display("[TB] txn pause pulse width=%0d", hi);
`endif

    // Randomized deaths, revivals, restarts and pauses in lockstep with the model.
    for (int blk = 0; blk < 6; blk++) begin
      for (int i = 0; i < 250; i++) begin
        if ($urandom_range(0, 7) == 0) tank_state[$urandom_range(0, 3)] ^= 1'b1;
        restart = ($urandom_range(0, 249) == 0);
`ifdef TANK_SPAWN_PAUSE_EN
        if ($urandom_range(0, 19) == 0) pause = ~pause;
`endif
        tick();
      end
      restart = 1'b0;
      $display("[TB] txn random block %0d complete, failures so far %0d", blk, tests_failed);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
